// File: rtl/bist_6_3_pkg.sv
// Shared types and golden model for the 6:3 counter BIST sequencer.
package bist_6_3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         PATTERN_COUNT = 64;
  localparam logic [5:0] LAST_PATTERN  = 6'd63;
  // The MISR seed is all-ones at whatever width it is built; replicate this bit.
  localparam logic       MISR_SEED_BIT = 1'b1;

  function automatic logic [2:0] popcount6(input logic [5:0] x);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 6; i++) c = c + {2'b00, x[i]};
    return c;
  endfunction

endpackage

// File: rtl/bist_6_3_controller_if.sv
// Controller-side bundle: test-controller status/command and CUT pins.
// Signature and SIG_W exist only when BIST_MISR_EN is defined.
interface bist_6_3_controller_if
  import bist_6_3_pkg::*;
#(
  parameter int FAIL_CNT_W = 7
`ifdef BIST_MISR_EN
  , parameter int SIG_W = 16
`endif
) ();
  // start/abort are level-sampled commands with no ready: start acts only in
  // IDLE/DONE, abort only in RUN/DONE; busy/done report the resulting state.
  logic                  start;
  logic                  abort;
  logic [5:0]            cut_x;
  logic [2:0]            cut_o;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [FAIL_CNT_W-1:0] fail_count;
  logic [5:0]            first_fail_pat;
  logic [2:0]            first_fail_resp;
  state_t                state;
`ifdef BIST_MISR_EN
  logic [SIG_W-1:0]      signature;

  modport master (input start, abort, cut_o,
                  output cut_x, busy, done, pass, fail_count,
                  first_fail_pat, first_fail_resp, state, signature);
  modport slave  (output start, abort, cut_o,
                  input cut_x, busy, done, pass, fail_count,
                  first_fail_pat, first_fail_resp, state, signature);
`else
  modport master (input start, abort, cut_o,
                  output cut_x, busy, done, pass, fail_count,
                  first_fail_pat, first_fail_resp, state);
  modport slave  (output start, abort, cut_o,
                  input cut_x, busy, done, pass, fail_count,
                  first_fail_pat, first_fail_resp, state);
`endif
endinterface

// File: rtl/bist_misr.sv
// Serial MISR compressing the 3-bit CUT response into an SIG_W-bit signature.
module bist_misr
  import bist_6_3_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= {SIG_W{MISR_SEED_BIT}};
    end else if (clear) begin
      sig <= {SIG_W{MISR_SEED_BIT}};
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(din);
    end
  end

endmodule

// File: rtl/bist_6_3_controller.sv
// BIST sequencer: walks all 64 patterns through the 6:3 counter and checks popcount.
// Optional signature compression is built when BIST_MISR_EN is defined.
module bist_6_3_controller
  import bist_6_3_pkg::*;
#(
  parameter int FAIL_CNT_W   = 7,
  parameter bit STOP_ON_FAIL = 1'b0
`ifdef BIST_MISR_EN
  , parameter int               SIG_W    = 16
  , parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
`endif
) (
  input logic                    clk,
  input logic                    rst,
  bist_6_3_controller_if.master  bus
);

  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX = '1;

  state_t state;
  logic   mismatch;
  logic   finish_run;
  logic   launch;
  logic   clear_req;

  always_comb begin
    mismatch   = (bus.cut_o != popcount6(bus.cut_x));
    finish_run = (bus.cut_x == LAST_PATTERN) || (STOP_ON_FAIL && mismatch);
    // abort outranks start in DONE; in IDLE abort is ignored entirely
    launch     = bus.start && ((state == IDLE) || (state == DONE && !bus.abort));
    clear_req  = bus.abort && (state != IDLE);
  end

  assign bus.state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      bus.cut_x           <= '0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.pass            <= 1'b0;
      bus.fail_count      <= '0;
      bus.first_fail_pat  <= '0;
      bus.first_fail_resp <= '0;
    end else if (clear_req || launch) begin
      state               <= launch ? RUN : IDLE;
      bus.busy            <= launch;
      bus.cut_x           <= '0;
      bus.done            <= 1'b0;
      bus.pass            <= 1'b0;
      bus.fail_count      <= '0;
      bus.first_fail_pat  <= '0;
      bus.first_fail_resp <= '0;
    end else if (state == RUN) begin
      if (mismatch) begin
        if (bus.fail_count != FAIL_MAX) bus.fail_count <= bus.fail_count + 1'b1;
        if (bus.fail_count == '0) begin
          bus.first_fail_pat  <= bus.cut_x;
          bus.first_fail_resp <= bus.cut_o;
        end
      end
      if (finish_run) begin
        state    <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.pass <= (bus.fail_count == '0) && !mismatch;
      end else begin
        bus.cut_x <= bus.cut_x + 6'd1;
      end
    end
  end

`ifdef BIST_MISR_EN
  bist_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_req || launch),
    .en    ((state == RUN) && !bus.abort),
    .din   (bus.cut_o),
    .sig   (bus.signature)
  );
`endif

endmodule

// File: tb/tb_bist_6_3_controller.sv
// Bench for bist_6_3_controller: two instances (run-to-end and stop-on-fail)
// against a fault-injecting CUT model; define BIST_MISR_EN to cover the MISR.
module tb_bist_6_3_controller;
  import bist_6_3_pkg::*;

  localparam int FCW = 7;
`ifdef BIST_MISR_EN
  localparam int         SW   = 16;
  localparam logic [15:0] POLY = 16'h1021;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bist_6_3_controller_if #(.FAIL_CNT_W(FCW)
`ifdef BIST_MISR_EN
    , .SIG_W(SW)
`endif
  ) bus_a ();
  bist_6_3_controller_if #(.FAIL_CNT_W(FCW)
`ifdef BIST_MISR_EN
    , .SIG_W(SW)
`endif
  ) bus_s ();

  bist_6_3_controller #(.FAIL_CNT_W(FCW), .STOP_ON_FAIL(1'b0)
`ifdef BIST_MISR_EN
    , .SIG_W(SW), .SIG_POLY(POLY)
`endif
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  bist_6_3_controller #(.FAIL_CNT_W(FCW), .STOP_ON_FAIL(1'b1)
`ifdef BIST_MISR_EN
    , .SIG_W(SW), .SIG_POLY(POLY)
`endif
  ) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  // ---------------- CUT model with fault injection ----------------
  logic [2:0] and_m = 3'b111;
  logic [2:0] or_m  = 3'b000;
  logic       ov_en = 1'b0;
  logic [5:0] ov_pat = '0;
  logic [2:0] ov_val = '0;

  function automatic logic [2:0] cut_resp(input logic [5:0] x, input logic [2:0] am,
                                          input logic [2:0] om, input logic oe,
                                          input logic [5:0] op, input logic [2:0] ov);
    logic [2:0] pop;
    pop = 3'($countones(x));
    if (oe && x == op) return ov;
    return (pop & am) | om;
  endfunction

  assign bus_a.cut_o = cut_resp(bus_a.cut_x, and_m, or_m, ov_en, ov_pat, ov_val);
  assign bus_s.cut_o = cut_resp(bus_s.cut_x, and_m, or_m, ov_en, ov_pat, ov_val);

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference results for the current fault configuration
  int         exp_fc;
  logic [5:0] exp_pat;
  logic [2:0] exp_resp;
  logic       exp_pass;
  int         s_m;
  int         s_fc;
  logic       s_pass;
`ifdef BIST_MISR_EN
  logic [15:0] exp_sig, s_sig, golden_sig;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [2:0] d);
    logic [15:0] n;
    n = s << 1;
    if (s[15]) n = n ^ POLY;
    return n ^ {13'd0, d};
  endfunction
`endif

  task automatic model();
    logic [2:0] r;
    bit seen;
    bit stopped;
    seen = 0; stopped = 0;
    exp_fc = 0; exp_pat = '0; exp_resp = '0; s_m = 63;
`ifdef BIST_MISR_EN
    exp_sig = 16'hFFFF; s_sig = 16'hFFFF;
`endif
    for (int p = 0; p < PATTERN_COUNT; p++) begin
      r = cut_resp(6'(p), and_m, or_m, ov_en, ov_pat, ov_val);
`ifdef BIST_MISR_EN
      exp_sig = misr_step(exp_sig, r);
      if (!stopped) s_sig = exp_sig;
`endif
      if (r != 3'($countones(6'(p)))) begin
        if (exp_fc < (1 << FCW) - 1) exp_fc++;
        if (!seen) begin seen = 1; exp_pat = 6'(p); exp_resp = r; end
        if (!stopped) begin stopped = 1; s_m = p; end
      end
    end
    exp_pass = (exp_fc == 0);
    s_fc     = seen ? 1 : 0;
    s_pass   = !seen;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    step();
    bus_a.start = 1'b1; bus_s.start = 1'b1;
    step();
    bus_a.start = 1'b0; bus_s.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " a cut_x"}, 32'(bus_a.cut_x), 32'd0);
    chk({tag, " a busy/done/pass"}, 32'({bus_a.busy, bus_a.done, bus_a.pass}), 32'd0);
    chk({tag, " a fail_count"}, 32'(bus_a.fail_count), 32'd0);
    chk({tag, " a first_fail"}, 32'({bus_a.first_fail_pat, bus_a.first_fail_resp}), 32'd0);
    chk({tag, " s cut_x"}, 32'(bus_s.cut_x), 32'd0);
    chk({tag, " s busy/done/pass"}, 32'({bus_s.busy, bus_s.done, bus_s.pass}), 32'd0);
    chk({tag, " s fail_count"}, 32'(bus_s.fail_count), 32'd0);
`ifdef BIST_MISR_EN
    chk({tag, " a signature"}, 32'(bus_a.signature), 32'h0000FFFF);
    chk({tag, " s signature"}, 32'(bus_s.signature), 32'h0000FFFF);
`endif
  endtask

  // Full run from a start pulse; checks the cycle-by-cycle walk and final results.
  task automatic run_full(input string tag);
    int last_s;
    logic       eb;
    logic [5:0] ecx;
    model();
    last_s = s_m + 1;
    pulse_start();
    for (int n = 1; n <= 66; n++) begin
      eb  = (n <= 64);
      ecx = eb ? 6'(n - 1) : 6'd63;
      chk({tag, " a busy/done/cut_x"}, 32'({bus_a.busy, bus_a.done, bus_a.cut_x}),
          32'({eb, !eb, ecx}));
      eb  = (n <= last_s);
      ecx = eb ? 6'(n - 1) : 6'(s_m);
      chk({tag, " s busy/done/cut_x"}, 32'({bus_s.busy, bus_s.done, bus_s.cut_x}),
          32'({eb, !eb, ecx}));
      step();
    end
    chk({tag, " a fail_count"}, 32'(bus_a.fail_count), 32'(exp_fc));
    chk({tag, " a pass"}, 32'(bus_a.pass), 32'(exp_pass));
    chk({tag, " a first_fail_pat"}, 32'(bus_a.first_fail_pat), 32'(exp_pat));
    chk({tag, " a first_fail_resp"}, 32'(bus_a.first_fail_resp), 32'(exp_resp));
    chk({tag, " s fail_count"}, 32'(bus_s.fail_count), 32'(s_fc));
    chk({tag, " s pass"}, 32'(bus_s.pass), 32'(s_pass));
    chk({tag, " s first_fail"}, 32'({bus_s.first_fail_pat, bus_s.first_fail_resp}),
        32'({exp_pat, exp_resp}));
`ifdef BIST_MISR_EN
    chk({tag, " a signature"}, 32'(bus_a.signature), 32'(exp_sig));
    chk({tag, " s signature"}, 32'(bus_s.signature), 32'(s_sig));
`endif
  endtask

  task automatic set_cfg(input logic [2:0] am, input logic [2:0] om, input logic oe,
                         input logic [5:0] op, input logic [2:0] ov);
    and_m = am; or_m = om; ov_en = oe; ov_pat = op; ov_val = ov;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    bus_s.start = 1'b0; bus_s.abort = 1'b0;
    #12;
    check_idle("reset");
    @(negedge clk); rst = 1'b0;

    set_cfg(3'b111, 3'b000, 1'b0, 6'd0, 3'd0);
    run_full("clean");
`ifdef BIST_MISR_EN
    golden_sig = exp_sig;
`endif
    repeat (3) step();
    chk("done holds", 32'({bus_a.done, bus_a.busy, bus_a.cut_x}), 32'({1'b1, 1'b0, 6'd63}));

    set_cfg(3'b110, 3'b000, 1'b0, 6'd0, 3'd0);
    run_full("bit0_stuck");
    set_cfg(3'b011, 3'b000, 1'b0, 6'd0, 3'd0);
    run_full("bit2_stuck");
    set_cfg(3'b111, 3'b000, 1'b1, 6'd7, 3'b010);
    run_full("pat7_fault");
`ifdef BIST_MISR_EN
    n_assert++;
    assert (bus_a.signature !== golden_sig) else begin
      n_fail++;
      $error("FAIL pat7 signature differs: observed=%0h golden=%0h", bus_a.signature, golden_sig);
    end
`endif

    for (int i = 0; i < 3; i++) begin
      set_cfg(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)),
              1'b1, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
      run_full("random");
    end

    // abort mid-run at pattern 20 (stop instance already sits in DONE)
    set_cfg(3'b110, 3'b000, 1'b0, 6'd0, 3'd0);
    pulse_start();
    repeat (20) step();
    chk("abort pre cut_x", 32'({bus_a.busy, bus_a.cut_x}), 32'({1'b1, 6'd20}));
    bus_a.abort = 1'b1; bus_s.abort = 1'b1;
    step();
    bus_a.abort = 1'b0; bus_s.abort = 1'b0;
    check_idle("abort");
    set_cfg(3'b111, 3'b000, 1'b0, 6'd0, 3'd0);
    run_full("after_abort");

    // start and abort together in DONE: abort wins
    bus_a.start = 1'b1; bus_a.abort = 1'b1; bus_s.start = 1'b1; bus_s.abort = 1'b1;
    step();
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_s.start = 1'b0; bus_s.abort = 1'b0;
    check_idle("start+abort");
    step();
    chk("start+abort stays idle", 32'({bus_a.busy, bus_a.cut_x}), 32'd0);

    // start ignored during RUN, then asynchronous reset at pattern 40
    set_cfg(3'b110, 3'b000, 1'b0, 6'd0, 3'd0);
    pulse_start();
    repeat (30) step();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    chk("start in run ignored", 32'({bus_a.busy, bus_a.cut_x}), 32'({1'b1, 6'd31}));
    repeat (9) step();
    chk("pre async rst", 32'(bus_a.cut_x), 32'd40);
    #3 rst = 1'b1;
    #1;
    check_idle("async_rst");
    #2 rst = 1'b0;
    set_cfg(3'b111, 3'b000, 1'b0, 6'd0, 3'd0);
    run_full("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_6_3_controller.md
Name: bist_6_3_controller

Overview:
- Built-in self-test sequencer for the combinational 6:3 binary counter.
- Drives all 64 input patterns into the counter under test (CUT) and checks each 3-bit response against an internal golden popcount.
- Accumulates a fail count and captures the first failing pattern.
- Sits between the top-level test controller (start/abort/status) and the CUT's x/o pins.

Parameters:
FAIL_CNT_W, 7, width of fail counter; saturates at all-ones.
STOP_ON_FAIL, 0, 1 = terminate the run at the first mismatch.
SIG_W, 16, MISR width (only with BIST_MISR_EN).
SIG_POLY, 16'h1021, MISR feedback polynomial (only with BIST_MISR_EN).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin test; sampled only in IDLE or DONE
abort  in  1  cancel test; effective in RUN
cut_x  out  6  pattern driven to CUT x inputs (registered)
cut_o  in  3  CUT response, combinational from cut_x
busy  out  1  high in RUN
done  out  1  high in DONE; holds until start or abort
pass  out  1  valid when done; 1 = zero mismatches
fail_count  out  FAIL_CNT_W  number of mismatching patterns
first_fail_pat  out  6  pattern of first mismatch
first_fail_resp  out  3  CUT response at first mismatch
signature  out  SIG_W  MISR value (only with BIST_MISR_EN)

Behaviour:
- Reset (async, any state) returns to IDLE with every output cleared:
  - cut_x=0, busy=0, done=0, pass=0, fail_count=0, first_fail_*=0.
  - signature = all-ones seed.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at edge k:
  - RUN from cycle k+1.
  - cut_x=0 and all result registers cleared.
  - Seed signature to all-ones.
- RUN, each cycle:
  - expected = popcount(cut_x) (3 bits, 0..6).
  - cut_o is compared in the same cycle; the result is registered at the next edge.
  - Mismatch updates:
    - fail_count += 1, saturating at 2^FAIL_CNT_W-1.
    - If this is the first mismatch, capture first_fail_pat=cut_x and first_fail_resp=cut_o.
  - cut_x increments by 1 each cycle.
  - Pattern 0 is applied in cycle k+1; pattern 63 in cycle k+64.
- End of run:
  - RUN -> DONE at the edge where pattern 63 is checked; done=1 and busy=0 from cycle k+65.
  - cut_x holds 63 in DONE.
  - STOP_ON_FAIL=1: the mismatching pattern is counted (fail_count=1), then go to DONE at the next edge. cut_x holds the failing pattern.
- pass = (fail_count==0), registered on DONE entry, held in DONE.
- abort:
  - In RUN, takes priority over mismatch and end-of-run. Next state IDLE with all outputs cleared as at reset.
  - In DONE, returns to IDLE (clear).
  - In IDLE, ignored.
- start in RUN is ignored. start and abort both high in DONE: abort wins.
- cut_o must settle within one clk period (combinational CUT). The controller never samples cut_o outside RUN.

Optional Feature:
BIST_MISR_EN
- Defined:
  - An SIG_W-bit MISR compresses cut_o each RUN cycle: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended cut_o.
  - Seeded to all-ones on start/reset.
  - Frozen in DONE.
  - signature port present.
- Not defined: no MISR logic, no signature port. pass/fail comes from direct compare only.

Decomposition:
- Package bist_6_3_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - PATTERN_COUNT=64, LAST_PATTERN=6'd63
  - MISR seed constant
  - popcount6 function (golden model)
- One sub-module is natural: bist_misr (SIG_W, SIG_POLY parameters; ports clk, rst, clear, en, din[2:0], sig). Instantiate it only under BIST_MISR_EN.

Test Plan:
- Fault-free CUT, start pulse at edge k -> busy high cycles k+1..k+64; cut_x walks 0..63; done=1 at k+65 with pass=1, fail_count=0; first_fail_* =0.
- cut_o[0] forced 0 -> fail_count=32, pass=0, first_fail_pat=6'd1, first_fail_resp=3'b000.
- STOP_ON_FAIL=1, cut_o[2] forced 0 -> first mismatch at pattern 15 (popcount 4); done at cycle k+17; fail_count=1; first_fail_pat=6'd15; first_fail_resp=3'b000; cut_x holds 15.
- abort asserted while cut_x=20 -> IDLE next cycle; busy=0, done=0, fail_count=0, cut_x=0; a later start runs the full 64 patterns cleanly.
- rst asserted asynchronously mid-RUN (cut_x=40) -> outputs clear immediately without waiting for clk; start pulsed again during RUN is ignored (cut_x continues incrementing).
- BIST_MISR_EN, fault-free run -> signature in DONE equals the bench reference-model MISR of popcount(0..63); a single-pattern fault (pattern 7 response 3'b010) yields a different signature.
